pipelined_dcache: RTL



---
 rtl/pipelined_dcache_pkg.sv | 26 ++
 rtl/pipelined_dcache_array.sv | 27 ++
 rtl/pipelined_dcache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipelined_dcache_pkg.sv
// Shared types and address helpers for the pipelined data cache.
package dcache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_t;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  // Helpers return full-width values; callers truncate to their own tag/index width.
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int s_index);
    return addr >> (OFFSET_W + s_index);
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int s_index);
    return (addr >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [2:0] word_of(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/pipelined_dcache_array.sv
// Flop array: asynchronous read, synchronous write, optional synchronous clear.
module dcache_array #(
  parameter int WIDTH    = 1,
  parameter int AW       = 3,
  parameter bit RESET_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (RESET_EN && rst) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pipelined_dcache.sv
// Direct-mapped write-back/write-allocate data cache answering the CPU MEM/WB port.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise both read as zero.
module pipelined_dcache
  import dcache_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read_b,
  input  logic         mem_write_b,
  input  logic [3:0]   mem_wmask_b,
  input  logic [31:0]  mem_address_b,
  input  logic [31:0]  mem_wdata_b,
  input  logic         mem_stall_b,
  output logic         mem_resp_b,
  output logic [31:0]  mem_rdata_b,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  // Handshake: pmem_read/pmem_write rise on entering ALLOCATE/WRITEBACK and stay
  // high with a stable pmem_address until the single-cycle pmem_resp; mem_resp_b
  // is valid only while a request is held and served from IDLE.

  dcache_state_t state;

  logic              req_valid;
  logic              req_is_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wmask;

  logic [S_INDEX-1:0] req_idx;
  logic [S_TAG-1:0]   req_tag;
  logic [2:0]         req_word;

  logic [LINE_W-1:0]  data_rd, data_wd, merged;
  logic [S_TAG-1:0]   tag_rd;
  logic               valid_rd, dirty_rd;
  logic               data_we, dirty_we, fill;
  logic               hit, serve, wr_hit, miss_start;

  assign req_idx  = S_INDEX'(index_of(req_addr, S_INDEX));
  assign req_tag  = S_TAG'(tag_of(req_addr, S_INDEX));
  assign req_word = word_of(req_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid    <= 1'b0;
      req_is_write <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wmask    <= '0;
    end else if (!mem_stall_b) begin
      req_valid    <= mem_read_b | mem_write_b;
      req_is_write <= mem_write_b;
      req_addr     <= mem_address_b;
      req_wdata    <= mem_wdata_b;
      req_wmask    <= mem_wmask_b;
    end
  end

  assign hit        = valid_rd && (tag_rd == req_tag);
  assign serve      = (state == IDLE) && req_valid && hit;
  assign wr_hit     = serve && req_is_write;
  assign miss_start = (state == IDLE) && req_valid && !hit;
  assign fill       = (state == ALLOCATE) && pmem_resp;

  // Store merge rewrites the same bytes every held cycle, so it is idempotent.
  always_comb begin
    merged = data_rd;
    for (int b = 0; b < 4; b++) begin
      if (req_wmask[b]) merged[{req_word, 2'(b), 3'b000} +: 8] = req_wdata[b*8 +: 8];
    end
  end

  assign data_we  = wr_hit | fill;
  assign data_wd  = fill ? pmem_rdata : merged;
  assign dirty_we = wr_hit | fill;

  dcache_array #(.WIDTH(LINE_W), .AW(S_INDEX), .RESET_EN(1'b0)) u_data (
    .clk(clk), .rst(rst), .we(data_we), .addr(req_idx), .wdata(data_wd), .rdata(data_rd)
  );

  dcache_array #(.WIDTH(S_TAG), .AW(S_INDEX), .RESET_EN(1'b0)) u_tag (
    .clk(clk), .rst(rst), .we(fill), .addr(req_idx), .wdata(req_tag), .rdata(tag_rd)
  );

  dcache_array #(.WIDTH(1), .AW(S_INDEX), .RESET_EN(1'b1)) u_valid (
    .clk(clk), .rst(rst), .we(fill), .addr(req_idx), .wdata(1'b1), .rdata(valid_rd)
  );

  dcache_array #(.WIDTH(1), .AW(S_INDEX), .RESET_EN(1'b1)) u_dirty (
    .clk(clk), .rst(rst), .we(dirty_we), .addr(req_idx), .wdata(!fill), .rdata(dirty_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (miss_start) state <= dirty_rd ? WRITEBACK : ALLOCATE;
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE:  if (pmem_resp) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign mem_resp_b  = serve;
  assign mem_rdata_b = (serve && !req_is_write) ? data_rd[{req_word, 5'b00000} +: 32] : 32'd0;

  assign pmem_write = (state == WRITEBACK);
  assign pmem_read  = (state == ALLOCATE);
  assign pmem_wdata = data_rd;

  always_comb begin
    pmem_address = 32'd0;
    if (state == WRITEBACK) pmem_address = {tag_rd, req_idx, S_OFFSET'(0)};
    else if (state == ALLOCATE) pmem_address = {req_tag, req_idx, S_OFFSET'(0)};
  end

`ifdef DCACHE_STATS_EN
  logic        resp_seen, req_missed;
  logic [31:0] hit_q, miss_q;

  // Flags live for one accepted request so stall-held and post-fill responses are not hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_seen  <= 1'b0;
      req_missed <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      resp_seen  <= mem_stall_b ? (resp_seen | serve) : 1'b0;
      req_missed <= mem_stall_b ? (req_missed | miss_start) : 1'b0;
      if (serve && !resp_seen && !req_missed) hit_q <= hit_q + 32'd1;
      if (miss_start) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
